// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port word memory.
// Round-robin grants, sub-word stores done as read-modify-write.
module mem_port_arbiter #(
  parameter int WORDS = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req_valid,
  input  logic [31:0] i_req_addr0,
  input  logic [31:0] i_req_addr1,
  input  logic        i_req_we0,
  input  logic        i_req_we1,
  input  logic [31:0] i_req_wdata0,
  input  logic [31:0] i_req_wdata1,
  input  logic [3:0]  i_req_be0,
  input  logic [3:0]  i_req_be1,
  output logic [1:0]  o_req_ready,
  output logic [1:0]  o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_write_data,
  output logic        o_mem_write_enable,
  input  logic [31:0] i_mem_read_data
);

  localparam logic [31:0] LP_LIMIT = 32'(WORDS * 4);

  typedef enum logic {
    S_IDLE,
    S_RMW_WR
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_rr_ptr;

  logic [1:0]  r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  logic [31:0] r_rmw_addr;
  logic [31:0] r_rmw_data;
  logic        r_rmw_port;

  logic [1:0]  w_grant;
  logic        w_gnt_any;
  logic        w_gnt_port;

  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_we;
  logic [3:0]  w_be;

  logic        w_err;
  logic        w_load;
  logic        w_full;
  logic        w_partial;
  logic [31:0] w_merged;

  // Grant selection: only in IDLE, ties broken by the round-robin pointer
  always_comb begin
    w_grant = 2'b00;
    if (r_state == S_IDLE && !i_rst) begin
      unique case (i_req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_rr_ptr ? 2'b10 : 2'b01;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_gnt_any  = |w_grant;
  assign w_gnt_port = w_grant[1];

  // Route the granted port's request fields onto a common bus
  always_comb begin
    w_addr  = i_req_addr0;
    w_wdata = i_req_wdata0;
    w_we    = i_req_we0;
    w_be    = i_req_be0;
    if (w_gnt_port) begin
      w_addr  = i_req_addr1;
      w_wdata = i_req_wdata1;
      w_we    = i_req_we1;
      w_be    = i_req_be1;
    end
  end

  // Classify the granted access: error, load, full store or partial store
  always_comb begin
    w_err     = (w_addr[1:0] != 2'b00) || (w_addr >= LP_LIMIT);
    w_load    = !w_we && !w_err;
    w_full    = w_we && !w_err && (w_be == 4'hF);
    w_partial = w_we && !w_err && (w_be != 4'hF) && (w_be != 4'h0);
  end

  // Merge store bytes over the word currently read from memory
  always_comb begin
    w_merged = i_mem_read_data;
    for (int i = 0; i < 4; i++) begin
      if (w_be[i]) w_merged[8*i +: 8] = w_wdata[8*i +: 8];
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state: a partial store takes one extra write cycle
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_gnt_any && w_partial) w_state_nxt = S_RMW_WR;
      S_RMW_WR: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: memory bus and grants; reset masks any write in flight
  always_comb begin
    o_req_ready        = w_grant;
    o_mem_address      = 32'h0;
    o_mem_write_data   = 32'h0;
    o_mem_write_enable = 1'b0;
    if (w_gnt_any) begin
      o_mem_address = w_addr;
      if (w_full) begin
        o_mem_write_data   = w_wdata;
        o_mem_write_enable = 1'b1;
      end
    end else if (r_state == S_RMW_WR && !i_rst) begin
      o_mem_address      = r_rmw_addr;
      o_mem_write_data   = r_rmw_data;
      o_mem_write_enable = 1'b1;
    end
  end

  // Pointer, response and read-modify-write capture registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr     <= 1'b0;
      r_resp_valid <= 2'b00;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
      r_rmw_addr   <= 32'h0;
      r_rmw_data   <= 32'h0;
      r_rmw_port   <= 1'b0;
    end else begin
      r_resp_valid <= 2'b00;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
      if (r_state == S_RMW_WR) begin
        r_resp_valid <= r_rmw_port ? 2'b10 : 2'b01;
      end else if (w_gnt_any) begin
        r_rr_ptr <= !w_gnt_port;
        if (w_partial) begin
          r_rmw_addr <= w_addr;
          r_rmw_data <= w_merged;
          r_rmw_port <= w_gnt_port;
        end else begin
          r_resp_valid <= w_grant;
          r_resp_rdata <= w_load ? i_mem_read_data : 32'h0;
          r_resp_err   <= w_err;
        end
      end
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural memory.
// Directed vectors; responses checked by an independent monitor.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  valid;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        we0, we1;
  logic [3:0]  be0, be1;
  logic [1:0]  ready, resp_valid;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        resp_err, mem_we;

  logic [31:0] mem [64];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_idx;
  logic [31:0] bd_data;

  typedef struct {
    logic [1:0]  port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORDS(64)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid),
    .i_req_addr0(addr0), .i_req_addr1(addr1),
    .i_req_we0(we0), .i_req_we1(we1),
    .i_req_wdata0(wdata0), .i_req_wdata1(wdata1),
    .i_req_be0(be0), .i_req_be1(be1),
    .o_req_ready(ready), .o_resp_valid(resp_valid),
    .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
    .o_mem_address(mem_addr), .o_mem_write_data(mem_wdata),
    .o_mem_write_enable(mem_we), .i_mem_read_data(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare on every response pulse
  always @(negedge clk) begin
    if (resp_valid != 2'b00) begin
      if (q.size() == 0) begin
        chk("unexpected_resp", {30'h0, resp_valid}, 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_port", {30'h0, resp_valid}, {30'h0, e.port});
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
      end
    end
  end

  task automatic push(input logic [1:0] p, input logic [31:0] d,
                      input logic e);
    exp_t x;
    x.port = p; x.rdata = d; x.err = e;
    q.push_back(x);
  endtask

  task automatic bd_write(input int idx, input logic [31:0] d);
    bd_idx = 6'(idx); bd_data = d; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 2'b00;
    @(posedge clk); #1;
    chk("rst_ready", {30'h0, ready}, 32'h0);
    chk("rst_resp_valid", {30'h0, resp_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'h0, resp_err}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    rst = 1'b0;
  endtask

  task automatic set_port(input int p, input logic [31:0] a,
                          input logic w, input logic [31:0] d,
                          input logic [3:0] b);
    if (p == 0) begin
      addr0 = a; we0 = w; wdata0 = d; be0 = b;
    end else begin
      addr1 = a; we1 = w; wdata1 = d; be1 = b;
    end
  endtask

  task automatic issue(input int p, input logic [31:0] a,
                       input logic w, input logic [31:0] d,
                       input logic [3:0] b, input logic [31:0] er,
                       input logic ee, output int waited);
    bit got;
    got = 1'b0; waited = 0;
    set_port(p, a, w, d, b);
    valid[p] = 1'b1;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (ready[p]) got = 1'b1;
      else waited++;
    end
    chk("ready_wait", {31'h0, got}, 32'h1);
    if (got) push(p == 0 ? 2'b01 : 2'b10, er, ee);
    @(posedge clk); #1;
    valid[p] = 1'b0;
  endtask

  initial begin
    int w;
    rst = 1'b1; valid = 2'b00;
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) bd_write(i, 32'h1000_0000 + i);
    bd_write(4, 32'hDEADBEEF);
    bd_write(2, 32'h11223344);
    do_reset();

    // 1: single fetch load, ready in the same cycle
    issue(0, 32'h10, 0, 0, 0, 32'hDEADBEEF, 0, w);
    chk("t1_ready_same_cycle", w, 0);

    // 2: both ports valid, grants alternate from port 0
    do_reset();
    set_port(0, 32'h10, 0, 0, 0);
    set_port(1, 32'h0C, 0, 0, 0);
    valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_grant", {30'h0, ready}, (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i % 2 == 0) push(2'b01, 32'hDEADBEEF, 0);
      else            push(2'b10, 32'h1000_0003, 0);
      @(posedge clk);
    end
    #1 valid = 2'b00;

    // 3: partial store RMW; fetch stalled during the write cycle
    set_port(1, 32'h8, 1, 32'h0000AB00, 4'b0010);
    valid[1] = 1'b1;
    @(negedge clk);
    chk("t3_grant_lsu", {30'h0, ready}, 32'h2);
    push(2'b10, 32'h0, 0);
    @(posedge clk); #1;
    valid[1] = 1'b0;
    set_port(0, 32'h10, 0, 0, 0);
    valid[0] = 1'b1;
    @(negedge clk);
    chk("t3_fetch_stalled", {30'h0, ready}, 32'h0);
    chk("t3_rmw_we", {31'h0, mem_we}, 32'h1);
    chk("t3_rmw_addr", mem_addr, 32'h8);
    chk("t3_rmw_data", mem_wdata, 32'h1122AB44);
    @(negedge clk);
    chk("t3_fetch_granted", {30'h0, ready}, 32'h1);
    push(2'b01, 32'hDEADBEEF, 0);
    @(posedge clk); #1;
    valid[0] = 1'b0;
    chk("t3_mem2", mem[2], 32'h1122AB44);

    // 4: misaligned and out-of-range accesses
    issue(1, 32'h6, 0, 0, 0, 32'h0, 1, w);
    issue(1, 32'h100, 0, 0, 0, 32'h0, 1, w);
    issue(1, 32'h100, 1, 32'hFFFFFFFF, 4'hF, 32'h0, 1, w);
    issue(0, 32'h1, 1, 32'hFFFFFFFF, 4'hF, 32'h0, 1, w);
    @(posedge clk); #1;
    chk("t4_mem0", mem[0], 32'h1000_0000);

    // 4b: no-op store with empty byte enables
    issue(0, 32'h4, 1, 32'hFFFFFFFF, 4'h0, 32'h0, 0, w);
    @(posedge clk); #1;
    chk("t4b_mem1", mem[1], 32'h1000_0001);

    // 5: reset during the RMW write cycle
    rst = 1'b1;
    bd_write(2, 32'h11223344);
    do_reset();
    set_port(1, 32'h8, 1, 32'h0000AB00, 4'b0010);
    valid[1] = 1'b1;
    @(negedge clk);
    chk("t5_grant", {30'h0, ready}, 32'h2);
    @(posedge clk); #1;
    valid[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_we_suppressed", {31'h0, mem_we}, 32'h0);
    chk("t5_ready", {30'h0, ready}, 32'h0);
    chk("t5_resp_valid", {30'h0, resp_valid}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_mem2", mem[2], 32'h11223344);

    // 6: full store then back-to-back load of the same word
    issue(1, 32'h4, 1, 32'hCAFEF00D, 4'hF, 32'h0, 0, w);
    issue(1, 32'h4, 0, 0, 0, 32'hCAFEF00D, 0, w);
    chk("t6_back_to_back", w, 0);

    begin
      int k;
      k = 0;
      while (q.size() != 0 && k < 20) begin
        @(posedge clk); k++;
      end
      @(negedge clk);
      chk("drain", q.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
